// File: rtl/pipe3_core.sv
// pipe3_core: three-stage (IF / ID / EX) register machine with loadable program
// memory, run/halt control, EX->ID operand forwarding and branch flush.
module pipe3_core #(
  parameter int DW     = 16,
  parameter int PDEPTH = 256,
  parameter int AW     = $clog2(PDEPTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          ce,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  output logic [DW-1:0] o,
  output logic          o_valid,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL,
    OP_SHR, OP_MOV, OP_JMP, OP_JZ, OP_OUT, OP_HALT, OP_RSV_E, OP_RSV_F
  } op_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          if_valid_q, if_valid_d;
  logic [15:0]   if_instr_q;
  logic          ex_valid_q, ex_valid_d;
  op_e           ex_op_q, ex_op_d;
  logic [3:0]    ex_rd_q, ex_rd_d;
  logic [DW-1:0] ex_a_q, ex_a_d;
  logic [DW-1:0] ex_b_q, ex_b_d;
  logic [7:0]    ex_imm_q, ex_imm_d;
  logic [DW-1:0] regs_q [16];
  logic [DW-1:0] regs_d [16];
  logic [DW-1:0] o_q, o_d;
  logic          o_valid_q, o_valid_d;
  logic [15:0]   mem_q [PDEPTH];

  // NOTE: the program memory and its read register carry no reset so they can map
  // onto RAM; the IF valid bit, which is reset, qualifies the fetched word.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (prog_we && (state_q != S_RUN)) mem_q[prog_addr] <= prog_data;
      if (state_q == S_RUN) if_instr_q <= mem_q[pc_q];
    end
  end

  // Execute stage
  logic          ex_writes, ex_taken, ex_halt, ex_out;
  logic [DW-1:0] ex_result;

  always_comb begin
    // NOTE: every combinational output is given a default first so no path
    // through the block can infer a latch.
    ex_result = '0;
    case (ex_op_q)
      OP_LDI:  ex_result = DW'(ex_imm_q);
      OP_ADD:  ex_result = ex_a_q + ex_b_q;
      OP_SUB:  ex_result = ex_a_q - ex_b_q;
      OP_AND:  ex_result = ex_a_q & ex_b_q;
      OP_OR:   ex_result = ex_a_q | ex_b_q;
      OP_XOR:  ex_result = ex_a_q ^ ex_b_q;
      OP_SHL:  ex_result = ex_a_q << 1;
      OP_SHR:  ex_result = ex_a_q >> 1;
      OP_MOV:  ex_result = ex_a_q;
      default: ex_result = '0;
    endcase
  end

  assign ex_writes = ex_valid_q && (ex_op_q >= OP_LDI) && (ex_op_q <= OP_MOV);
  assign ex_taken  = ex_valid_q && ((ex_op_q == OP_JMP) ||
                                    ((ex_op_q == OP_JZ) && (ex_a_q == '0)));
  assign ex_halt   = ex_valid_q && (ex_op_q == OP_HALT);
  assign ex_out    = ex_valid_q && (ex_op_q == OP_OUT);

  // Decode stage; JZ tests the register named in the rd field, so operand A
  // is selected from rd for JZ and rs otherwise.
  op_e           id_op;
  logic [3:0]    id_rd, id_rs, id_rt, id_a_sel;
  logic [DW-1:0] id_a, id_b;

  always_comb begin
    id_op    = op_e'(if_instr_q[15:12]);
    id_rd    = if_instr_q[11:8];
    id_rs    = if_instr_q[7:4];
    id_rt    = if_instr_q[3:0];
    id_a_sel = (id_op == OP_JZ) ? id_rd : id_rs;
    id_a     = (ex_writes && (ex_rd_q == id_a_sel)) ? ex_result : regs_q[id_a_sel];
    id_b     = (ex_writes && (ex_rd_q == id_rt))    ? ex_result : regs_q[id_rt];
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    regs_d     = regs_q;
    o_d        = o_q;
    o_valid_d  = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d    = S_RUN;
          pc_d       = '0;
          if_valid_d = 1'b0;
          ex_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (ex_writes) regs_d[ex_rd_q] = ex_result;
        if (ex_out) begin
          o_d       = ex_a_q;
          o_valid_d = 1'b1;
        end
        ex_valid_d = if_valid_q;
        ex_op_d    = id_op;
        ex_rd_d    = id_rd;
        ex_a_d     = id_a;
        ex_b_d     = id_b;
        ex_imm_d   = if_instr_q[7:0];
        if_valid_d = 1'b1;
        pc_d       = pc_q + AW'(1);
        // HALT and a taken branch both squash the two younger stages.
        if (ex_halt) begin
          state_d    = S_HALTED;
          pc_d       = pc_q;
          if_valid_d = 1'b0;
          ex_valid_d = 1'b0;
        end else if (ex_taken) begin
          pc_d       = ex_imm_q[AW-1:0];
          if_valid_d = 1'b0;
          ex_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      if_valid_q <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= OP_NOP;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      regs_q     <= '{default: '0};
      o_q        <= '0;
      o_valid_q  <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      regs_q     <= regs_d;
      o_q        <= o_d;
      o_valid_q  <= o_valid_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign busy    = (state_q == S_RUN);
  assign halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_pipe3_core.sv
// Testbench for pipe3_core: scenario tasks with an output scoreboard; a DW=8
// instance runs alongside to cover narrow-width wrap.
module tb_pipe3_core;

  localparam logic [3:0] I_NOP = 4'h0, I_LDI = 4'h1, I_ADD = 4'h2, I_SUB = 4'h3,
                         I_XOR = 4'h6, I_SHL = 4'h7, I_SHR = 4'h8, I_JMP = 4'hA,
                         I_JZ  = 4'hB, I_OUT = 4'hC, I_HALT = 4'hD;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [15:0] o;
  logic        o_valid, busy, halted;
  logic [7:0]  o8;
  logic        o_valid8, busy8, halted8;

  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  bit          ce_s;
  logic [15:0] mon_exp;
  logic [15:0] exp_q[$];
  int          out_edges[$];
  logic [15:0] prog_q[$];

  always #5 clk = ~clk;

  pipe3_core #(.DW(16), .PDEPTH(256)) dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .o(o), .o_valid(o_valid), .busy(busy), .halted(halted)
  );

  pipe3_core #(.DW(8), .PDEPTH(16)) dut8 (
    .clk(clk), .clr_n(clr_n), .ce(ce), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr[3:0]), .prog_data(prog_data),
    .o(o8), .o_valid(o_valid8), .busy(busy8), .halted(halted8)
  );

  // en_cnt numbers the ce-enabled edges; an OUT is logged against the edge it committed on.
  always @(posedge clk) begin
    ce_s = ce;
    if (ce) en_cnt++;
  end

  always @(negedge clk) begin
    if (clr_n && ce_s && o_valid) begin
      out_edges.push_back(en_cnt);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: o=%h at edge %0d with nothing expected", o, en_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o !== mon_exp) begin
          errors++;
          $display("FAIL out_value: got %h want %h at edge %0d", o, mon_exp, en_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] r3(input logic [3:0] op, rd, rs, rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog_q.size(); i++) begin
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = prog_q[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic do_start(output int e0);
    out_edges.delete();
    start = 1'b1;
    e0    = en_cnt + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int budget, output int halt_en, output bit ok);
    ok      = 1'b0;
    halt_en = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (halted === 1'b1) begin
        ok      = 1'b1;
        halt_en = en_cnt;
        break;
      end
    end
  endtask

  task automatic set_loop_prog();
    prog_q = '{ri(I_LDI, 4'd1, 8'd3), ri(I_LDI, 4'd2, 8'd1), r3(I_OUT, 4'd0, 4'd1, 4'd0),
               r3(I_SUB, 4'd1, 4'd1, 4'd2), ri(I_JZ, 4'd1, 8'd6), ri(I_JMP, 4'd0, 8'd2),
               r3(I_HALT, 4'd0, 4'd0, 4'd0)};
  endtask

  task automatic test_reset();
    #3 clr_n = 1'b0;
    #1;
    checks++; if (o !== 16'h0)      begin errors++; $display("FAIL reset_o: got %h want 0000", o); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (halted !== 1'b0)  begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    repeat (2) @(posedge clk);
    #2 clr_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b halted=%b want 0/0", busy, halted);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = {I_HALT, 12'h000};
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic test_forwarding();
    int e0, he;
    bit ok;
    prog_q = '{ri(I_LDI, 4'd1, 8'd5), ri(I_LDI, 4'd2, 8'd3), r3(I_ADD, 4'd3, 4'd1, 4'd2),
               r3(I_SUB, 4'd4, 4'd3, 4'd1), r3(I_OUT, 4'd0, 4'd3, 4'd0),
               r3(I_OUT, 4'd0, 4'd4, 4'd0), r3(I_HALT, 4'd0, 4'd0, 4'd0)};
    load_prog();
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd3);
    do_start(e0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fwd_busy_after_start: got %b want 1", busy); end
    run_until_halt(100, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fwd_halt_timeout: got no halt want halt"); end
    checks++; if (he !== e0 + 9) begin errors++; $display("FAIL fwd_halt_edge: got %0d want %0d", he, e0 + 9); end
    checks++; if (out_edges.size() != 2) begin
      errors++; $display("FAIL fwd_out_count: got %0d want 2", out_edges.size());
    end else begin
      checks++; if (out_edges[0] != e0 + 7) begin
        errors++; $display("FAIL fwd_first_out_edge: got %0d want %0d", out_edges[0], e0 + 7);
      end
      checks++; if (out_edges[1] != e0 + 8) begin
        errors++; $display("FAIL fwd_second_out_edge: got %0d want %0d", out_edges[1], e0 + 8);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fwd_pending: got %0d left want 0", exp_q.size()); end
    checks++; if (busy !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL fwd_halted_state: got busy=%b halted=%b want 0/1", busy, halted);
    end
  endtask

  task automatic check_loop_timing(input string tag, input int e0, input int he);
    checks++; if (he !== e0 + 22) begin errors++; $display("FAIL %s_halt_edge: got %0d want %0d", tag, he, e0 + 22); end
    checks++; if (out_edges.size() != 3) begin
      errors++; $display("FAIL %s_out_count: got %0d want 3", tag, out_edges.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (out_edges[i] != e0 + 5 + 6 * i) begin
          errors++; $display("FAIL %s_out_edge%0d: got %0d want %0d", tag, i, out_edges[i], e0 + 5 + 6 * i);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_pending: got %0d left want 0", tag, exp_q.size()); end
  endtask

  task automatic test_loop();
    int e0, he;
    bit ok;
    set_loop_prog();
    load_prog();
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd1);
    do_start(e0);
    run_until_halt(200, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_halt_timeout: got no halt want halt"); end
    check_loop_timing("loop", e0, he);
  endtask

  task automatic test_wrap();
    int e0, he;
    bit ok;
    prog_q = '{ri(I_LDI, 4'd1, 8'd0), ri(I_LDI, 4'd2, 8'd1), r3(I_SUB, 4'd3, 4'd1, 4'd2),
               r3(I_SHR, 4'd7, 4'd3, 4'd0), r3(I_XOR, 4'd8, 4'd3, 4'd7),
               r3(I_OUT, 4'd0, 4'd8, 4'd0), r3(I_SHL, 4'd9, 4'd8, 4'd0),
               r3(I_OUT, 4'd0, 4'd9, 4'd0), r3(I_OUT, 4'd0, 4'd3, 4'd0),
               r3(I_HALT, 4'd0, 4'd0, 4'd0)};
    load_prog();
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFFFF);
    do_start(e0);
    run_until_halt(100, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_halt_timeout: got no halt want halt"); end
    checks++; if (he !== e0 + 12) begin errors++; $display("FAIL wrap_halt_edge: got %0d want %0d", he, e0 + 12); end
    checks++; if (out_edges.size() != 3) begin errors++; $display("FAIL wrap_out_count: got %0d want 3", out_edges.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d left want 0", exp_q.size()); end
    checks++; if (o8 !== 8'hFF) begin errors++; $display("FAIL wrap_dw8_o: got %h want ff", o8); end
    checks++; if (halted8 !== 1'b1) begin errors++; $display("FAIL wrap_dw8_halted: got %b want 1", halted8); end
  endtask

  task automatic test_ce_freeze();
    int e0, he, n;
    bit ok;
    set_loop_prog();
    load_prog();
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd1);
    do_start(e0);
    n = 0;
    while (en_cnt < e0 + 5 && n < 50) begin
      tick();
      n++;
    end
    checks++; if (en_cnt != e0 + 5) begin errors++; $display("FAIL ce_reach_edge: got %0d want %0d", en_cnt, e0 + 5); end
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (o !== 16'd3 || o_valid !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL ce_hold%0d: got o=%h v=%b busy=%b want 0003/1/1", i, o, o_valid, busy);
      end
    end
    ce = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0 || o !== 16'd3) begin
      errors++; $display("FAIL ce_resume: got o=%h v=%b want 0003/0", o, o_valid);
    end
    run_until_halt(200, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ce_halt_timeout: got no halt want halt"); end
    check_loop_timing("ce", e0, he);
  endtask

  task automatic test_guards();
    int e0, he;
    bit ok;
    prog_q = '{r3(I_OUT, 4'd0, 4'd4, 4'd0), ri(I_LDI, 4'd4, 8'h42),
               r3(I_NOP, 4'd0, 4'd0, 4'd0), r3(I_NOP, 4'd0, 4'd0, 4'd0),
               r3(I_NOP, 4'd0, 4'd0, 4'd0), r3(I_NOP, 4'd0, 4'd0, 4'd0),
               r3(I_HALT, 4'd0, 4'd0, 4'd0)};
    load_prog();
    exp_q.push_back(16'd3);
    do_start(e0);
    prog_we   = 1'b1;
    prog_addr = 8'd0;
    prog_data = r3(I_OUT, 4'd0, 4'd9, 4'd0);
    start     = 1'b1;
    repeat (3) tick();
    prog_we = 1'b0;
    start   = 1'b0;
    run_until_halt(100, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL guard_halt_timeout: got no halt want halt"); end
    checks++; if (he !== e0 + 9) begin errors++; $display("FAIL guard_no_restart: halt edge got %0d want %0d", he, e0 + 9); end
    checks++; if (out_edges.size() != 1) begin errors++; $display("FAIL guard_out_count: got %0d want 1", out_edges.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL guard_pending: got %0d left want 0", exp_q.size()); end
    exp_q.push_back(16'h0042);
    do_start(e0);
    run_until_halt(100, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL guard_rerun_timeout: got no halt want halt"); end
    checks++; if (he !== e0 + 9) begin errors++; $display("FAIL guard_rerun_edge: got %0d want %0d", he, e0 + 9); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL guard_rerun_pending: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midrun();
    int e0, he, n;
    bit ok;
    set_loop_prog();
    load_prog();
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd1);
    do_start(e0);
    n = 0;
    while (en_cnt < e0 + 7 && n < 50) begin
      tick();
      n++;
    end
    #1 clr_n = 1'b0;
    #1;
    checks++; if (o !== 16'h0)      begin errors++; $display("FAIL midrst_o: got %h want 0000", o); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid: got %b want 0", o_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (halted !== 1'b0)  begin errors++; $display("FAIL midrst_halted: got %b want 0", halted); end
    checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL midrst_first_out: got %0d left want 2", exp_q.size()); end
    exp_q.delete();
    @(posedge clk);
    #2 clr_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: got busy=%b want 0", busy); end
    prog_q = '{r3(I_OUT, 4'd0, 4'd1, 4'd0), r3(I_OUT, 4'd0, 4'd2, 4'd0),
               r3(I_OUT, 4'd0, 4'd4, 4'd0), r3(I_HALT, 4'd0, 4'd0, 4'd0)};
    load_prog();
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    do_start(e0);
    run_until_halt(100, he, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_rerun_timeout: got no halt want halt"); end
    checks++; if (he !== e0 + 6) begin errors++; $display("FAIL midrst_rerun_edge: got %0d want %0d", he, e0 + 6); end
    checks++; if (out_edges.size() != 3) begin errors++; $display("FAIL midrst_out_count: got %0d want 3", out_edges.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_pending: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_forwarding();
    test_loop();
    test_wrap();
    test_ce_freeze();
    test_guards();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe3_core.md
# pipe3_core

Parametrised successor to the team's 3-stage processor. It is a fetch / decode / execute pipelined register machine with configurable data width and program depth. It adds a loadable program memory, a run/halt control FSM, EX→ID operand forwarding, and a conditional branch with pipeline flush. The block sits at the top of the CPU hierarchy and drives the observable output bus `o`.

## Interface
- `DW`, 16: datapath and register width; legal range 8..32.
- `PDEPTH`, 256: program memory words; power of two, 2..256.
- `AW`, $clog2(PDEPTH): derived; program address width.
- `clk`  in  1  single clock, rising-edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `ce`  in  1  clock enable; low freezes all state, including memory writes.
- `start`  in  1  level-sampled; begins execution at pc 0 when in IDLE or HALTED.
- `prog_we`  in  1  program memory write strobe; honoured only outside RUN.
- `prog_addr`  in  AW  program write address.
- `prog_data`  in  16  instruction word to write.
- `o`  out  DW  output register, written by OUT.
- `o_valid`  out  1  one-cycle pulse when `o` is updated.
- `busy`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.

## Operation
- Instruction word fields: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt, [7:0] imm8. The block has 16 registers r0..r15; r0 is ordinary.
- 0 NOP.
- 1 LDI: rd = zero-extended imm8.
- 2 ADD: rd = rs+rt.
- 3 SUB: rd = rs-rt.
- 4 AND, 5 OR, 6 XOR: bitwise on rs, rt.
- 7 SHL: rd = rs<<1.
- 8 SHR: rd = rs>>1, logical.
- 9 MOV: rd = rs.
- A JMP imm8.
- B JZ: field [11:8] is the test register; jump to imm8 if that register is 0.
- C OUT rs: o = rs.
- D HALT.
- E, F behave as NOP.
- Arithmetic wraps modulo 2^DW. Jump targets are imm8[AW-1:0]. pc wraps from PDEPTH-1 to 0.
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → HALTED when HALT executes in EX.
  - HALTED → RUN on `start`.
  - `start` is ignored in RUN.
- Entering RUN: pc=0 and all pipeline valid bits are cleared. Registers and `o` are retained.
- Stages:
  - IF: synchronous memory read at pc into the IF/ID register.
  - ID: decode and register read into the ID/EX operand registers.
  - EX: ALU, register writeback, `o` update, branch resolve.
- Forwarding: if the EX instruction writes register X and the ID instruction reads X, ID takes the EX result. Back-to-back dependencies never stall.
- Taken JMP/JZ in EX: pc ← target; the IF/ID and ID/EX entries are squashed. Penalty is 2 bubbles. A not-taken JZ has no penalty.
- HALT in EX: younger entries are squashed, no further writes occur, and pc is frozen.
- Program memory is not reset. `prog_we` is written at the edge in IDLE/HALTED and ignored in RUN.

## Timing
- Reset (async, clr_n=0):
  - FSM=IDLE; pc=0; valids=0; r0..r15=0.
  - o=0, o_valid=0, busy=0, halted=0.
  - Reset mid-run aborts immediately, with no partial writeback.
- `start` sampled at edge E0 (ce=1) → busy=1 after E0.
- First instruction:
  - Fetched at E1.
  - In EX during the cycle after E2.
  - Its writeback, `o` and `o_valid` take effect at E3.
- Throughput: 1 instruction per ce-enabled cycle.
- Taken branch at edge Eb: the target instruction commits at Eb+3.
- HALT commits at edge Eh → busy=0 and halted=1 after Eh.
- `o_valid` is high exactly one ce-enabled cycle per OUT and is cleared on the next ce-enabled edge. While ce=0 it holds its value.
- `prog_we` and `start` in the same IDLE edge: the write lands first. A write to address 0 is visible to the first fetch at E1.
- ce=0: all registers, FSM and memory hold. Resuming ce=1 continues the same cycle sequence with nothing skipped or duplicated.

## Test plan
- **Reset.** Run a program, then assert clr_n=0 mid-run → o=0, o_valid=0, busy=0, halted=0 asynchronously. After release, a new `start` re-executes from pc 0 with r*=0.
- **Forwarding chain** (DW=16). Program: LDI r1,5; LDI r2,3; ADD r3,r1,r2; SUB r4,r3,r1; OUT r3; OUT r4; HALT → o=8 then o=3, two o_valid pulses 1 cycle apart, halted=1. First OUT commits at E7.
- **Loop/branch.** Program: LDI r1,3; LDI r2,1; L: OUT r1; SUB r1,r1,r2; JZ r1,end; JMP L; end: HALT → o sequence 3,2,1. Each taken JMP shows exactly 2 bubble cycles between OUTs.
- **Wrap.** LDI r1,0; LDI r2,1; SUB r3,r1,r2; OUT r3 → o=0xFFFF at DW=16 and 0xFF at DW=8. SHL of 0x8000 → 0x0000.
- **ce freeze.** Drop ce for 5 cycles mid-loop → o, busy and pc are unchanged throughout. After ce returns high, the output sequence and spacing match a run without the freeze.
- **Control guards.** prog_we during RUN → memory unchanged when re-read after HALT. `start` during RUN → no restart. `start` in HALTED → rerun from pc 0 with registers retained.
